audio_frame_serializer: RTL and testbench

//  Parallel-to-serial stage fed by the 32-cycle one-hot load generator on the audio DAC path.

---
 rtl/audio_frame_serializer.sv | 92 +++++++++
 tb/tb_audio_frame_serializer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/audio_frame_serializer.sv
// audio_frame_serializer: buffers stereo pairs, loads them on each frame pulse and shifts them out MSB-first with LR clock (SER_I2S_DELAY_EN adds one-bit I2S data delay)
module audio_frame_serializer #(
    parameter int DATA_W    = 16,
    parameter bit HOLD_LAST = 1'b0
) (
    input  logic              s_clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] audio_in_left,
    input  logic [DATA_W-1:0] audio_in_right,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sdata,
    output logic              lrck,
    output logic              frame_start,
    output logic              underrun,
    output logic              sync_err
);
    localparam int FRAME_W = 2 * DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    logic [FRAME_W-1:0] r_hold, r_shift, r_last;
    logic               r_hold_full, r_running, r_frame_start, r_underrun, r_sync_err;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0] w_in;
    logic               w_last_bit;

    assign w_in       = {audio_in_left, audio_in_right};
    assign w_last_bit = r_bit_cnt == CNT_W'(FRAME_W - 1);

    // frame loading, holding-buffer handshake, shifting and sticky error flags
    always_ff @(negedge s_clk or posedge rst) begin
        if (rst) begin
            r_hold        <= '0;
            r_shift       <= '0;
            r_last        <= '0;
            r_hold_full   <= 1'b0;
            r_running     <= 1'b0;
            r_bit_cnt     <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_start <= load;
            if (load) begin
                r_bit_cnt <= '0;
                r_running <= 1'b1;
                if (r_running && !w_last_bit) r_sync_err <= 1'b1;
                if (r_hold_full) begin
                    r_shift     <= r_hold;
                    r_last      <= r_hold;
                    r_hold_full <= 1'b0;
                end else if (in_valid) begin
                    r_shift <= w_in;
                    r_last  <= w_in;
                end else begin
                    r_shift    <= HOLD_LAST ? r_last : '0;
                    r_underrun <= 1'b1;
                end
            end else begin
                if (in_valid && !r_hold_full) begin
                    r_hold      <= w_in;
                    r_hold_full <= 1'b1;
                end
                if (r_running) begin
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SER_I2S_DELAY_EN
    logic r_sdata_d;

    // one-bit data delay so the MSB follows the LR clock edge
    always_ff @(negedge s_clk or posedge rst) begin
        if (rst) r_sdata_d <= 1'b0;
        else     r_sdata_d <= r_shift[FRAME_W-1];
    end

    assign sdata = r_sdata_d;
`else
    assign sdata = r_shift[FRAME_W-1];
`endif

    assign in_ready    = ~r_hold_full;
    assign lrck        = r_bit_cnt >= CNT_W'(DATA_W);
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign sync_err    = r_sync_err;
endmodule

// File: tb/tb_audio_frame_serializer.sv
// tb_audio_frame_serializer: scoreboard bench driving HOLD_LAST=0 and HOLD_LAST=1 instances with identical directed stimulus
module tb_audio_frame_serializer;
    logic        s_clk = 1'b0;
    logic        rst, load, in_valid;
    logic [15:0] left, right;
    logic        rdy0, sd0, lr0, fs0, ur0, se0;
    logic        rdy1, sd1, lr1, fs1, ur1, se1;

    typedef struct packed {
        logic sd0, sd1, rdy, lr, fs, ur, se;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic hf = 1'b0;
    logic p0 = 1'b0;
    logic p1 = 1'b0;

    always #5 s_clk = ~s_clk;

    audio_frame_serializer #(.DATA_W(16), .HOLD_LAST(1'b0)) u_dut0 (
        .s_clk(s_clk), .rst(rst), .load(load), .audio_in_left(left), .audio_in_right(right),
        .in_valid(in_valid), .in_ready(rdy0), .sdata(sd0), .lrck(lr0), .frame_start(fs0),
        .underrun(ur0), .sync_err(se0)
    );

    audio_frame_serializer #(.DATA_W(16), .HOLD_LAST(1'b1)) u_dut1 (
        .s_clk(s_clk), .rst(rst), .load(load), .audio_in_left(left), .audio_in_right(right),
        .in_valid(in_valid), .in_ready(rdy1), .sdata(sd1), .lrck(lr1), .frame_start(fs1),
        .underrun(ur1), .sync_err(se1)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: outputs are stable at the rising edge, half a period after the falling update edge
    always @(posedge s_clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sdata0", sd0, e.sd0);
            chk("sdata1", sd1, e.sd1);
            chk("in_ready0", rdy0, e.rdy);
            chk("in_ready1", rdy1, e.rdy);
            chk("lrck0", lr0, e.lr);
            chk("lrck1", lr1, e.lr);
            chk("frame_start0", fs0, e.fs);
            chk("frame_start1", fs1, e.fs);
            chk("underrun0", ur0, e.ur);
            chk("underrun1", ur1, e.ur);
            chk("sync_err0", se0, e.se);
            chk("sync_err1", se1, e.se);
        end
    end

    task automatic check_reset();
        chk("rst_sdata0", sd0, 1'b0);
        chk("rst_sdata1", sd1, 1'b0);
        chk("rst_lrck0", lr0, 1'b0);
        chk("rst_frame_start0", fs0, 1'b0);
        chk("rst_underrun0", ur0, 1'b0);
        chk("rst_sync_err0", se0, 1'b0);
        chk("rst_in_ready0", rdy0, 1'b1);
        chk("rst_in_ready1", rdy1, 1'b1);
    endtask

    task automatic edge_step(input logic ld, input logic vld, input logic [15:0] l, input logic [15:0] r,
                             input logic b0, input logic b1, input logic rdy, input logic lr,
                             input logic fs, input logic ur, input logic se);
        exp_t e;
        @(posedge s_clk);
        load = ld; in_valid = vld; left = l; right = r;
        @(negedge s_clk);
        #1;
`ifdef SER_I2S_DELAY_EN
        e.sd0 = p0; e.sd1 = p1;
        p0 = b0; p1 = b1;
`else
        e.sd0 = b0; e.sd1 = b1;
`endif
        e.rdy = rdy; e.lr = lr; e.fs = fs; e.ur = ur; e.se = se;
        q.push_back(e);
    endtask

    // a0 = -2 keeps in_valid high on every edge with {l0,r0}; otherwise valid only at edges a0/a1
    task automatic send_frame(input logic [31:0] f0, input logic [31:0] f1, input int len,
                              input int a0, input int a1, input logic [15:0] l0, input logic [15:0] r0,
                              input logic [15:0] l1, input logic [15:0] r1, input logic ur, input logic se);
        for (int i = 0; i < len; i++) begin
            logic ld, vld;
            ld  = i == 0;
            vld = (a0 == -2) || (i == a0) || (i == a1);
            if (ld) hf = 1'b0;
            else if (vld && !hf) hf = 1'b1;
            edge_step(ld, vld, (i == a1) ? l1 : l0, (i == a1) ? r1 : r0,
                      f0[31-i], f1[31-i], !hf, i >= 16, i == 0, ur, se);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; in_valid = 1'b0; left = '0; right = '0;
        #3 check_reset();
        @(posedge s_clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) edge_step(0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0, 0);
        edge_step(0, 1, 16'hA5F0, 16'h0F0F, 0, 0, 0, 0, 0, 0, 0);
        hf = 1'b1;
        send_frame(32'hA5F00F0F, 32'hA5F00F0F, 32, -1, -1, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
        send_frame(32'h00000000, 32'hA5F00F0F, 32, -1, -1, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0);
        send_frame(32'h12348001, 32'h12348001, 32, 0, 5, 16'h1234, 16'h8001, 16'h5555, 16'hAAAA, 1, 0);
        send_frame(32'h5555AAAA, 32'h5555AAAA, 11, 2, -1, 16'hC3C3, 16'h3C3C, 16'h0, 16'h0, 1, 0);
        send_frame(32'hC3C33C3C, 32'hC3C33C3C, 32, -2, -1, 16'h7E7E, 16'h0101, 16'h0, 16'h0, 1, 1);
        send_frame(32'h7E7E0101, 32'h7E7E0101, 32, -2, -1, 16'h7E7E, 16'h0101, 16'h0, 16'h0, 1, 1);
        send_frame(32'h7E7E0101, 32'h7E7E0101, 20, -1, -1, 16'h0, 16'h0, 16'h0, 16'h0, 1, 1);
        @(posedge s_clk);
        #2 rst = 1'b1;
        #1 check_reset();
        hf = 1'b0; p0 = 1'b0; p1 = 1'b0;
        @(negedge s_clk);
        @(posedge s_clk); #1 rst = 1'b0;
        send_frame(32'h80018001, 32'h80018001, 32, 0, -1, 16'h8001, 16'h8001, 16'h0, 16'h0, 0, 0);
        for (int i = 0; i < 2; i++) edge_step(0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) @(posedge s_clk);
        #1 chk("scoreboard_drained", q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
